// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use a shift-add loop and DIV/DIVU a restoring loop, both one bit
// per cycle. Signed ops run on magnitudes and a FIX cycle restores the signs.
// MTHI/MTLO write HI/LO directly. The pipeline is held while the unit works.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  stall_request,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] op_b;      // multiplicand or divisor magnitude
    logic [DATA_WIDTH-1:0] acc_hi;    // product high half / remainder
    logic [DATA_WIDTH-1:0] acc_lo;    // multiplier shifting out / quotient
    logic                  op_div;
    logic                  neg_1;
    logic                  neg_2;

    logic                  is_mul, is_div, is_signed, div_zero, accept;
    logic [DATA_WIDTH-1:0] abs_1, abs_2;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH-1:0]   rem_shift;
    logic [DATA_WIDTH:0]     trial;
    logic                    trial_ok;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix;

    // Instruction decode and acceptance of a new multiply/divide.
    always_comb begin
        is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
        is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        div_zero  = is_div && (operand_2 == '0);
        accept    = (state == IDLE) && start && !flush && (is_mul || is_div);
        abs_1     = (is_signed && operand_1[DATA_WIDTH-1]) ? -operand_1 : operand_1;
        abs_2     = (is_signed && operand_2[DATA_WIDTH-1]) ? -operand_2 : operand_2;
    end

    // One iteration step for both loops plus the sign fix-up of the result.
    always_comb begin
        // 65-bit {carry, acc_hi, acc_lo} add-then-shift: the carry lands in
        // acc_hi's MSB after the shift, so it never needs its own register.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        // A set bit shifted out of the remainder means the 33-bit partial
        // remainder already exceeds any divisor, so the trial always succeeds.
        rem_shift = {acc_hi[DATA_WIDTH-2:0], acc_lo[DATA_WIDTH-1]};
        trial     = {1'b0, rem_shift} - {1'b0, op_b};
        trial_ok  = acc_hi[DATA_WIDTH-1] || !trial[DATA_WIDTH];
        prod_fix  = (neg_1 ^ neg_2) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = (neg_1 ^ neg_2) ? -acc_lo : acc_lo;
        rem_fix   = neg_1 ? -acc_hi : acc_hi;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = div_zero ? DONE : BUSY;
            BUSY: if (count == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Pipeline-facing status outputs.
    always_comb begin
        stall_request = 1'b0;
        if (!flush) begin
            case (state)
                IDLE:      stall_request = start && (is_mul || is_div);
                BUSY, FIX: stall_request = 1'b1;
                default:   stall_request = 1'b0;
            endcase
        end
        busy = (state == BUSY) || (state == FIX);
        done = (state == DONE) && !flush;
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            op_b   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            op_div <= 1'b0;
            neg_1  <= 1'b0;
            neg_2  <= 1'b0;
        end else if (accept) begin
            count  <= CNT_LAST;
            op_div <= is_div;
            neg_1  <= is_signed && operand_1[DATA_WIDTH-1];
            neg_2  <= is_signed && operand_2[DATA_WIDTH-1];
            acc_hi <= '0;
            if (is_div) begin
                op_b   <= abs_2;
                acc_lo <= abs_1;
            end else begin
                op_b   <= abs_1;
                acc_lo <= abs_2;
            end
        end else if (state == BUSY) begin
            count <= count - CNT_ONE;
            if (op_div) begin
                acc_hi <= trial_ok ? trial[DATA_WIDTH-1:0] : rem_shift;
                acc_lo <= {acc_lo[DATA_WIDTH-2:0], trial_ok};
            end else begin
                acc_hi <= mul_sum[DATA_WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
            end
        end
    end

    // HI/LO register writes; a flush suppresses every write in its cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush) begin
            if (state == IDLE && start) begin
                if (funct == FUNCT_MTHI) hi <= operand_1;
                if (funct == FUNCT_MTLO) lo <= operand_1;
                if (accept && div_zero) begin
                    hi <= operand_1;
                    lo <= '1;
                end
            end else if (state == FIX) begin
                if (op_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo <= prod_fix[DATA_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, flush and reset cases.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_request;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct        (funct),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .flush        (flush),
        .stall_request(stall_request),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Issue one op at a negedge (cycle 0) and observe until done or timeout.
    // Returns at negedge+1 of the done cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int stall_cnt, output int busy_cnt, output int done_at);
        stall_cnt = 0;
        busy_cnt  = 0;
        done_at   = -1;
        @(negedge clk);
        start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (stall_request) stall_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
        n_cmp++; if ({stall_request, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl got %b want 000", {stall_request, busy, done});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_multu();
        int s, bc, d;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, s, bc, d);
        n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL multu_done_at got %0d want 34", d); end
        n_cmp++; if (s !== 34) begin n_fail++; $display("FAIL multu_stall_cycles got %0d want 34", s); end
        n_cmp++; if (bc !== 33) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
        @(negedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult();
        int s, bc, d;
        run_op(F_MULT, 32'hFFFFFFFD, 32'h00000007, s, bc, d);
        n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL mult_neg_done_at got %0d want 34", d); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo); end
        run_op(F_MULT, 32'h80000000, 32'h80000000, s, bc, d);
        n_cmp++; if (hi !== 32'h40000000) begin n_fail++; $display("FAIL mult_min_hi got %h want 40000000", hi); end
        n_cmp++; if (lo !== 32'h00000000) begin n_fail++; $display("FAIL mult_min_lo got %h want 00000000", lo); end
    endtask

    task automatic test_div();
        int s, bc, d;
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, s, bc, d);
        n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL div_neg_done_at got %0d want 34", d); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        run_op(F_DIVU, 32'd100, 32'd7, s, bc, d);
        n_cmp++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %0d want 14", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %0d want 2", hi); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, s, bc, d);
        n_cmp++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
        run_op(F_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, s, bc, d);
        n_cmp++; if (lo !== 32'd1) begin n_fail++; $display("FAIL divu_big_lo got %h want 00000001", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_big_hi got %h want 00000001", hi); end
    endtask

    task automatic test_div_zero();
        int s, bc, d;
        run_op(F_DIV, 32'h12345678, 32'h0, s, bc, d);
        n_cmp++; if (d !== 1) begin n_fail++; $display("FAIL div0_done_at got %0d want 1", d); end
        n_cmp++; if (s !== 1) begin n_fail++; $display("FAIL div0_stall_cycles got %0d want 1", s); end
        n_cmp++; if (bc !== 0) begin n_fail++; $display("FAIL div0_busy_cycles got %0d want 0", bc); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL div0_hi got %h want 12345678", hi); end
    endtask

    task automatic test_flush();
        int done_seen;
        @(negedge clk);
        start = 1'b1; funct = F_MULT; operand_1 = 32'h00001234; operand_2 = 32'h00005678;
        #1;
        n_cmp++; if (stall_request !== 1'b1) begin n_fail++; $display("FAIL flush_start_stall got %b want 1", stall_request); end
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_stall got %b want 0", stall_request); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_done got %b want 0", done); end
        @(negedge clk); flush = 1'b0; #1;
        n_cmp++; if ({busy, stall_request} !== 2'b00) begin
            n_fail++; $display("FAIL flush_idle got busy,stall=%b want 00", {busy, stall_request});
        end
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (done) done_seen++;
        end
        n_cmp++; if (done_seen !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d pulses want 0", done_seen); end
        n_cmp++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL flush_hi_kept got %h want 12345678", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL flush_lo_kept got %h want ffffffff", lo); end
        // MTHI writes after one edge with no stall
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; operand_1 = 32'hA5A5A5A5; #1;
        n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %b want 0", stall_request); end
        @(negedge clk); start = 1'b0; #1;
        n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mthi_hi got %h want a5a5a5a5", hi); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done got %b want 0", done); end
        // MTLO dropped by a same-cycle flush
        @(negedge clk);
        start = 1'b1; funct = F_MTLO; operand_1 = 32'hDEADBEEF; flush = 1'b1;
        @(negedge clk); start = 1'b0; flush = 1'b0; #1;
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mtlo_flush_lo got %h want ffffffff", lo); end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        start = 1'b1; funct = F_MFHI; operand_1 = 32'h0BADF00D; operand_2 = 32'h1; #1;
        n_cmp++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL other_funct_stall got %b want 0", stall_request); end
        @(negedge clk); start = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL other_funct_busy got %b want 0", busy); end
        n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL other_funct_hi got %h want a5a5a5a5", hi); end
    endtask

    task automatic test_reset_mid();
        int s, bc, d;
        @(negedge clk);
        start = 1'b1; funct = F_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 00000000", lo); end
        n_cmp++; if ({busy, stall_request, done} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_ctl got %b want 000", {busy, stall_request, done});
        end
        @(negedge clk); rst = 1'b1;
        run_op(F_MULTU, 32'd3, 32'd5, s, bc, d);
        n_cmp++; if (d !== 34) begin n_fail++; $display("FAIL post_rst_done_at got %0d want 34", d); end
        n_cmp++; if (lo !== 32'd15) begin n_fail++; $display("FAIL post_rst_lo got %0d want 15", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi got %0d want 0", hi); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; funct = 6'h0; operand_1 = '0; operand_2 = '0; flush = 1'b0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with its own HI/LO registers, sitting beside the EX stage.
- Executes MULT/MULTU/DIV/DIVU as a multi-cycle sequence and holds the pipeline through a stall request until the result is written.
- Services MTHI/MTLO writes; HI/LO are exposed to the EX result mux for MFHI/MFLO.
- Shares EX's funct/operand_1/operand_2 inputs; funct encodings are those of funct.v.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width. The iteration count equals DATA_WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  EX holds a valid instruction for this unit
funct  input  6  FUNCT_MULT/MULTU/DIV/DIVU/MTHI/MTLO; any other value is ignored
operand_1  input  32  rs value: multiplicand or dividend; write data for MTHI/MTLO
operand_2  input  32  rt value: multiplier or divisor
flush  input  1  synchronous cancel of the in-flight operation
stall_request  output  1  to pipeline control; holds PC, IF/ID and ID/EX
busy  output  1  state is BUSY or FIX
done  output  1  one-cycle pulse; HI/LO hold the new result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=lo=0, busy=done=stall_request=0, counter=0, internal accumulators=0. Reset mid-operation aborts the operation with no write.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - start with MULT/MULTU/DIV/DIVU: latch |op| (signed ops) or raw operands, latch the sign flags, load counter=31, go to BUSY. stall_request=1 combinationally in this cycle.
  - start with a DIV/DIVU whose operand_2==0: skip the iteration and go to DONE with lo=32'hFFFFFFFF, hi=operand_1.
  - start with MTHI/MTLO: hi/lo <= operand_1 at the next edge. No stall, no done pulse; state stays IDLE.
- BUSY: one iteration per cycle, counter decrements, stall_request=1. At counter==0, go to FIX.
  - Multiply: shift-add on a 65-bit {carry, acc_hi, acc_lo} register. If acc_lo[0]=1, add the multiplicand to {carry, acc_hi}; then shift right by 1.
  - Divide: restoring. Shift {rem, quo} left by 1; trial = rem - divisor over 33 bits; if non-negative, rem=trial and quo[0]=1.
- FIX: one cycle, stall_request=1.
  - Signed multiply: negate the 64-bit product when the sign flags of op1 and op2 differ.
  - Signed divide: negate the quotient when the sign flags differ; the remainder takes the sign of the dividend.
  - Write hi/lo at the end of the cycle, go to DONE.
- DONE: done=1, stall_request=0 so the instruction leaves EX. start is ignored in this cycle. Go to IDLE next.
- Latency: start accepted at cycle T. stall_request is high over T..T+33 (34 cycles). done=1 and the new hi/lo are visible at T+34.
  - Divide by zero: stall at T only, done at T+1.
- busy: high in BUSY and FIX only.
- start while BUSY or FIX is ignored; the operands are already latched.
- flush has priority over all other events in every state:
  - next state is IDLE; hi/lo are not written;
  - stall_request is forced 0 in the flush cycle and done stays 0;
  - a start in the same cycle as flush is dropped, including MTHI/MTLO.
- Arithmetic corner cases, all modulo 2^32 with no exceptions:
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - MULT 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0.
- Non-muldiv funct with start=1: no effect and no stall.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF at T -> stall_request high for 34 cycles; done at T+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0x12345678 / 0 -> done at T+1; lo=0xFFFFFFFF, hi=0x12345678; stall for exactly one cycle.
- MULT started, flush at T+10 -> IDLE next cycle; stall_request 0 in the flush cycle; hi/lo keep their prior values; no done. Then MTHI 0xA5A5A5A5 -> hi=0xA5A5A5A5 after one edge, no stall. Also: MTLO with flush in the same cycle -> lo unchanged.
- rst driven low at T+20 of a DIVU -> hi=lo=0 and busy=stall_request=done=0 immediately. After rst release, a new MULTU 3x5 -> lo=15, hi=0 at T'+34.
